// File: rtl/ex_pkg.sv
// Shared constants for the execute-stage divide sequencer: state encodings,
// RV32M divide funct codes, and a conditional-negate helper.
package ex_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 6;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift/subtract step: shifts {rem,quo} left and keeps the
// subtraction only when the shifted remainder covers the divisor.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0]   rem_sh;
    logic [XLEN+1:0] trial;
    logic            unused_trial_msb;

    assign rem_sh = {rem_i, quo_i[XLEN-1]};
    // One guard bit beyond 33 so the sign test holds for unsigned divisors near 2^32.
    assign trial  = {1'b0, rem_sh} - {2'b00, divisor_i};
    assign unused_trial_msb = trial[XLEN];

    assign rem_o = trial[XLEN+1] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
    assign quo_o = {quo_i[XLEN-2:0], ~trial[XLEN+1]};

endmodule

// File: rtl/ex_div_seq.sv
// RV32M DIV/DIVU/REM/REMU sequencer (restoring, 32 iterations).
// Build option EX_DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish straight from PREP.
module ex_div_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic [2:0]      funct_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    import ex_pkg::*;

    logic [2:0]       state_q, state_d;
    logic [2:0]       funct_q, funct_d;
    logic [XLEN-1:0]  a_q, a_d, b_q, b_d;
    logic [XLEN-1:0]  rem_q, rem_d, quo_q, quo_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d, b_zero_q, b_zero_d;
    logic [XLEN-1:0]  step_rem, step_quo, fix_quo, fix_rem;
    logic             is_signed, is_rem;

    assign is_signed = (funct_q == F_DIV) || (funct_q == F_REM);
    assign is_rem    = (funct_q == F_REM) || (funct_q == F_REMU);

    div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (b_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // Divide-by-zero keeps the all-ones quotient and the dividend as remainder.
    assign fix_quo = cond_neg(quo_q, (sign_a_q ^ sign_b_q) & ~b_zero_q);
    assign fix_rem = cond_neg(rem_q, sign_a_q);

    always_comb begin
        state_d  = state_q;
        funct_d  = funct_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        b_zero_d = b_zero_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    funct_d = funct_i[2] ? funct_i : F_DIVU;
                    a_d     = op_a_i;
                    b_d     = op_b_i;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                sign_a_d = is_signed & a_q[XLEN-1];
                sign_b_d = is_signed & b_q[XLEN-1];
                b_zero_d = (b_q == '0);
                quo_d    = cond_neg(a_q, is_signed & a_q[XLEN-1]);
                b_d      = cond_neg(b_q, is_signed & b_q[XLEN-1]);
                rem_d    = '0;
                cnt_d    = CNT_W'(XLEN - 1);
                state_d  = S_ITER;
`ifdef EX_DIV_EARLY_OUT_EN
                if (b_q == '0) begin
                    result_d = is_rem ? a_q : '1;
                    state_d  = S_DONE;
                end else if (is_signed && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1)) begin
                    result_d = is_rem ? '0 : a_q;
                    state_d  = S_DONE;
                end
`endif
            end
            S_ITER: begin
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FIX: begin
                result_d = is_rem ? fix_rem : fix_quo;
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_i) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            funct_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            funct_q  <= funct_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            b_zero_q <= b_zero_d;
        end
    end

    assign ready_o  = (state_q == S_IDLE);
    assign stall_o  = ~flush_i & ((state_q == S_PREP) || (state_q == S_ITER) || (state_q == S_FIX) ||
                                  ((state_q == S_IDLE) && start_i));
    assign done_o   = (state_q == S_DONE) & ~flush_i;
    assign result_o = result_q;

endmodule

// File: tb/tb_ex_div_seq.sv
// Directed bench for ex_div_seq: results, latency, flush, async reset, held start.
module tb_ex_div_seq;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  funct_i = 3'b000;
    logic [31:0] op_a_i = '0;
    logic [31:0] op_b_i = '0;
    logic        flush_i = 1'b0;
    logic        ready_o, stall_o, done_o;
    logic [31:0] result_o;

    int n_checks = 0;
    int n_errors = 0;

`ifdef EX_DIV_EARLY_OUT_EN
    localparam int LAT_SPECIAL = 1;
`else
    localparam int LAT_SPECIAL = 34;
`endif
    // Rising edges from the accepting edge until done is seen (34 = cycle N+35).
    localparam int LAT_FULL = 34;

    ex_div_seq dut (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .start_i  (start_i),
        .funct_i  (funct_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .flush_i  (flush_i),
        .ready_o  (ready_o),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int k;
        funct_i = f;
        op_a_i  = a;
        op_b_i  = b;
        start_i = 1'b1;
        #1;
        check({tag, "_stall_req"}, 32'(stall_o), 32'd1);
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        k = 0;
        while (!done_o && k < 60) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        check({tag, "_lat"}, 32'(k), 32'(exp_lat));
        check({tag, "_res"}, result_o, exp);
        check({tag, "_stall_done"}, 32'(stall_o), 32'd0);
        @(posedge clk_i);
        #1;
        check({tag, "_done_pulse"}, 32'(done_o), 32'd0);
        check({tag, "_ready_after"}, 32'(ready_o), 32'd1);
    endtask

    initial begin
        int dn;
        int acc;

        #1;
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_result", result_o, 32'd0);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        run_op("divu_100_7",  3'b101, 32'd100,       32'd7,          32'h0000000E, LAT_FULL);
        run_op("remu_100_7",  3'b111, 32'd100,       32'd7,          32'h00000002, LAT_FULL);
        run_op("div_m7_2",    3'b100, 32'hFFFFFFF9,  32'd2,          32'hFFFFFFFD, LAT_FULL);
        run_op("rem_m7_2",    3'b110, 32'hFFFFFFF9,  32'd2,          32'hFFFFFFFF, LAT_FULL);
        run_op("div_5_0",     3'b100, 32'd5,         32'd0,          32'hFFFFFFFF, LAT_SPECIAL);
        run_op("rem_m7_0",    3'b110, 32'hFFFFFFF9,  32'd0,          32'hFFFFFFF9, LAT_SPECIAL);
        run_op("remu_5_0",    3'b111, 32'd5,         32'd0,          32'h00000005, LAT_SPECIAL);
        run_op("div_ovf",     3'b100, 32'h80000000,  32'hFFFFFFFF,   32'h80000000, LAT_SPECIAL);
        run_op("rem_ovf",     3'b110, 32'h80000000,  32'hFFFFFFFF,   32'h00000000, LAT_SPECIAL);
        run_op("divu_big",    3'b101, 32'hFFFFFFFF,  32'h00000010,   32'h0FFFFFFF, LAT_FULL);
        run_op("remu_big",    3'b111, 32'hFFFFFFFF,  32'hFFFFFFFE,   32'h00000001, LAT_FULL);
        run_op("divu_ovf",    3'b101, 32'h80000000,  32'hFFFFFFFF,   32'h00000000, LAT_FULL);
        run_op("bad_funct",   3'b011, 32'd20,        32'd6,          32'h00000003, LAT_FULL);
        run_op("rem_7_m2",    3'b110, 32'd7,         32'hFFFFFFFE,   32'h00000001, LAT_FULL);

        // Flush together with start in IDLE: nothing is accepted.
        funct_i = 3'b101; op_a_i = 32'd50; op_b_i = 32'd5;
        start_i = 1'b1; flush_i = 1'b1;
        #1;
        check("idle_flush_stall", 32'(stall_o), 32'd0);
        @(posedge clk_i);
        #1;
        check("idle_flush_ready", 32'(ready_o), 32'd1);
        start_i = 1'b0; flush_i = 1'b0;

        // Flush at ITER cycle 10.
        funct_i = 3'b101; op_a_i = 32'd1000; op_b_i = 32'd3;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (11) @(posedge clk_i);
        #1;
        check("iter_stall", 32'(stall_o), 32'd1);
        flush_i = 1'b1;
        #1;
        check("flush_stall", 32'(stall_o), 32'd0);
        check("flush_done", 32'(done_o), 32'd0);
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        check("flush_ready", 32'(ready_o), 32'd1);
        dn = 0;
        repeat (40) begin
            @(posedge clk_i);
            #1;
            if (done_o) dn++;
        end
        check("flush_no_done", 32'(dn), 32'd0);
        run_op("divu_9_3", 3'b101, 32'd9, 32'd3, 32'h00000003, LAT_FULL);

        // Asynchronous reset in the middle of ITER.
        funct_i = 3'b101; op_a_i = 32'd1000; op_b_i = 32'd3;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (15) @(posedge clk_i);
        #1;
        rst_n_i = 1'b0;
        #1;
        check("arst_ready", 32'(ready_o), 32'd1);
        check("arst_stall", 32'(stall_o), 32'd0);
        check("arst_done", 32'(done_o), 32'd0);
        check("arst_result", result_o, 32'd0);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        dn = 0;
        repeat (40) begin
            @(posedge clk_i);
            #1;
            if (done_o) dn++;
        end
        check("arst_no_done", 32'(dn), 32'd0);

        // Start held high: re-accepted only once back in IDLE (edges 0, 36, 72).
        funct_i = 3'b101; op_a_i = 32'd20; op_b_i = 32'd5;
        start_i = 1'b1;
        acc = 0;
        dn = 0;
        for (int i = 0; i < 80; i++) begin
            if (ready_o) acc++;
            @(posedge clk_i);
            #1;
            if (done_o) begin
                dn++;
                check("held_res", result_o, 32'd4);
            end
        end
        start_i = 1'b0;
        repeat (40) begin
            @(posedge clk_i);
            #1;
            if (done_o) dn++;
        end
        check("held_accepts", 32'(acc), 32'd3);
        check("held_dones", 32'(dn), 32'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
